// File: rtl/swo_decoder_ctrl.sv
// -----------------------------------------------------------------------------
// swo_decoder_ctrl
//
// Controls the SWO Manchester decoder and the SWO UART/NRZ decoder. It holds
// both decoders in reset and then releases them so that it can detect which
// encoding is present. It locks onto the decoder that wins, and it scans again
// when the link is lost. Each decoder signals a byte by toggling its avail
// line. The controller turns the winner's toggles into a valid/ready byte
// stream through a small show-ahead FIFO.
//
// Ports
//   clk         module clock (shared with both decoders)
//   rst         asynchronous active-high reset
//   enable      low forces IDLE and flushes the FIFO
//   forceMode   00/11 auto-detect, 01 Manchester only, 10 UART only
//   manchAvail  Manchester byte indicator (toggle per byte)
//   manchByte   Manchester completed byte
//   uartAvail   UART byte indicator (toggle per byte)
//   uartByte    UART completed byte
//   manchRst    reset to the Manchester decoder
//   uartRst     reset to the UART decoder
//   outByte     FIFO head byte (0 when empty)
//   outValid    FIFO non-empty
//   outReady    consumer accepts head byte when outValid && outReady
//   mode        00 none, 01 Manchester locked, 10 UART locked
//   locked      high while in LOCKED
//   overflow    sticky, set when a byte is dropped on a full FIFO
//   clearOvf    single-cycle clear of overflow (a set in the same cycle wins)
// -----------------------------------------------------------------------------
module swo_decoder_ctrl #(
    parameter int TIMEOUT_W  = 20,
    parameter int LOCK_BYTES = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] forceMode,
    input  logic       manchAvail,
    input  logic [7:0] manchByte,
    input  logic       uartAvail,
    input  logic [7:0] uartByte,
    output logic       manchRst,
    output logic       uartRst,
    output logic [7:0] outByte,
    output logic       outValid,
    input  logic       outReady,
    output logic [1:0] mode,
    output logic       locked,
    output logic       overflow,
    input  logic       clearOvf
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SCAN    = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_RESTART = 2'd3
    } state_t;

    state_t                 state_reg, state_next;
    logic                   win_reg, win_next;          // 0 = Manchester, 1 = UART
    logic [1:0]             force_prev_reg;
    logic                   prev_manch_reg, prev_uart_reg;
    logic                   manch_rst_d_reg, uart_rst_d_reg;
    logic [3:0]             cnt_manch_reg, cnt_manch_next;
    logic [3:0]             cnt_uart_reg, cnt_uart_next;
    logic [TIMEOUT_W-1:0]   timer_reg, timer_next;
    logic [1:0]             mode_reg;
    logic                   locked_reg;
    logic                   overflow_reg, overflow_next;
    logic [AW:0]            wr_ptr_reg, rd_ptr_reg;
    logic [7:0]             mem [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // Byte event detection. A toggle counts only when the decoder was out
    // of reset in the previous cycle. This masks the glitch that a decoder
    // can produce on its avail line as it leaves reset.
    // ------------------------------------------------------------------
    logic ev_manch, ev_uart;
    assign ev_manch = (manchAvail != prev_manch_reg) && !manch_rst_d_reg;
    assign ev_uart  = (uartAvail  != prev_uart_reg)  && !uart_rst_d_reg;

    logic force_auto, force_changed;
    assign force_auto    = (forceMode[0] == forceMode[1]);
    assign force_changed = (forceMode != force_prev_reg);

    logic [3:0] cnt_manch_inc, cnt_uart_inc;
    logic       manch_hit, uart_hit;
    assign cnt_manch_inc = cnt_manch_reg + 4'(ev_manch);
    assign cnt_uart_inc  = cnt_uart_reg  + 4'(ev_uart);
    assign manch_hit     = ev_manch && (cnt_manch_inc == 4'(LOCK_BYTES));
    assign uart_hit      = ev_uart  && (cnt_uart_inc  == 4'(LOCK_BYTES));

    logic       win_ev;
    logic [7:0] win_byte;
    assign win_ev   = win_reg ? ev_uart  : ev_manch;
    assign win_byte = win_reg ? uartByte : manchByte;

    // Link loss is declared on the idle cycle in which the timer reaches
    // all-ones. This applies in auto mode only.
    logic [TIMEOUT_W-1:0] timer_inc;
    logic                 timeout;
    assign timer_inc = timer_reg + TIMEOUT_W'(1);
    assign timeout   = force_auto && !win_ev && (timer_inc == '1);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            win_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            win_reg   <= win_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        win_next   = win_reg;
        if (!enable) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE, ST_RESTART: begin
                    if (forceMode == 2'b01) begin
                        state_next = ST_LOCKED;
                        win_next   = 1'b0;
                    end else if (forceMode == 2'b10) begin
                        state_next = ST_LOCKED;
                        win_next   = 1'b1;
                    end else begin
                        state_next = ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (force_changed) begin
                        state_next = ST_RESTART;
                    end else if (manch_hit) begin
                        // Manchester is checked first, so it wins a tie.
                        state_next = ST_LOCKED;
                        win_next   = 1'b0;
                    end else if (uart_hit) begin
                        state_next = ST_LOCKED;
                        win_next   = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (force_changed) begin
                        state_next = ST_RESTART;
                    end else if (timeout) begin
                        state_next = ST_SCAN;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: decoder reset outputs
    // ------------------------------------------------------------------
    always_comb begin
        manchRst = 1'b1;
        uartRst  = 1'b1;
        case (state_reg)
            ST_SCAN: begin
                manchRst = 1'b0;
                uartRst  = 1'b0;
            end
            ST_LOCKED: begin
                manchRst = win_reg;
                uartRst  = !win_reg;
            end
            default: begin
                manchRst = 1'b1;
                uartRst  = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Counters, timer, edge history and registered status
    // ------------------------------------------------------------------
    always_comb begin
        cnt_manch_next = 4'd0;
        cnt_uart_next  = 4'd0;
        timer_next     = '0;
        if (state_reg == ST_SCAN && state_next == ST_SCAN) begin
            cnt_manch_next = cnt_manch_inc;
            cnt_uart_next  = cnt_uart_inc;
        end
        if (state_reg == ST_LOCKED && state_next == ST_LOCKED) begin
            timer_next = win_ev ? '0 : timer_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            force_prev_reg  <= 2'b00;
            prev_manch_reg  <= 1'b0;
            prev_uart_reg   <= 1'b0;
            manch_rst_d_reg <= 1'b1;
            uart_rst_d_reg  <= 1'b1;
            cnt_manch_reg   <= 4'd0;
            cnt_uart_reg    <= 4'd0;
            timer_reg       <= '0;
            mode_reg        <= 2'b00;
            locked_reg      <= 1'b0;
        end else begin
            force_prev_reg  <= forceMode;
            prev_manch_reg  <= manchAvail;
            prev_uart_reg   <= uartAvail;
            manch_rst_d_reg <= manchRst;
            uart_rst_d_reg  <= uartRst;
            cnt_manch_reg   <= cnt_manch_next;
            cnt_uart_reg    <= cnt_uart_next;
            timer_reg       <= timer_next;
            locked_reg      <= (state_next == ST_LOCKED);
            if (state_next == ST_LOCKED) begin
                mode_reg <= win_next ? 2'b10 : 2'b01;
            end else begin
                mode_reg <= 2'b00;
            end
        end
    end

    assign mode   = mode_reg;
    assign locked = locked_reg;

    // ------------------------------------------------------------------
    // Show-ahead FIFO. The read is combinational from the array so that a
    // byte written in cycle N is already at the head in cycle N+1.
    // ------------------------------------------------------------------
    logic fifo_empty, fifo_full, rd_en, wr_req, wr_en, drop;
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign rd_en      = !fifo_empty && outReady;
    assign wr_req     = enable && (state_reg == ST_LOCKED) && win_ev;
    // A write to a full FIFO succeeds only if a read frees a slot in the same cycle.
    assign wr_en      = wr_req && (!fifo_full || rd_en);
    assign drop       = wr_req && fifo_full && !rd_en;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg[AW-1:0]] <= win_byte;
        end
    end

    always_comb begin
        overflow_next = overflow_reg;
        if (drop) begin
            overflow_next = 1'b1;
        end else if (clearOvf) begin
            overflow_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            overflow_reg <= 1'b0;
        end else begin
            overflow_reg <= overflow_next;
            if (!enable) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (wr_en) begin
                    wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
                end
                if (rd_en) begin
                    rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
                end
            end
        end
    end

    assign outValid = !fifo_empty;
    assign outByte  = fifo_empty ? 8'h00 : mem[rd_ptr_reg[AW-1:0]];
    assign overflow = overflow_reg;

endmodule
